serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Shares one 6-bit parallel-to-serial transmit path between NREQ requesters.
- Grants requesters round-robin, latches the winner's word, and shifts it out LSB-first with a frame-start marker and a configurable idle gap between frames.
- Sits between several word producers and the single serial output line. It is both the scheduler and the sequencer for the serializer datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 6, bits per word (>=2).
- GAP, 1, idle cycles inserted after each frame (0..15).
- IDW, 2, width of gnt_id; must equal clog2(NREQ).

Ports:
- clk  in  1  clock; all logic on rising edge.
- clr  in  1  reset; synchronous, active-high.
- req  in  NREQ  request per requester. Level; held until ack.
- data  in  NREQ*WIDTH  requester words; requester i uses data[i*WIDTH +: WIDTH].
- ack  out  NREQ  one-cycle pulse to the granted requester.
- gnt_id  out  IDW  index of the requester whose frame is in progress or last sent.
- ser_out  out  1  serial data bit.
- ser_valid  out  1  high while ser_out carries a payload bit.
- frame_start  out  1  high during bit 0 of each frame.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (clr=1 at an edge): takes effect on the following cycle, including mid-frame, and aborts any frame in progress.
  - State goes to IDLE.
  - ack, gnt_id, ser_out, ser_valid, frame_start and busy all go to 0.
  - Bit and gap counters go to 0.
  - Round-robin pointer last = NREQ-1, so req[0] has top priority after reset.
- States:
  - IDLE: nothing in progress.
  - SHIFT: bit counter cnt runs 0..WIDTH-1.
  - GAP: gap counter gc runs 0..GAP-1.
- Decision edge: any rising edge where one of the following holds:
  - state=IDLE;
  - state=SHIFT, cnt=WIDTH-1 and GAP=0;
  - state=GAP and gc=GAP-1.
- At a decision edge with any req bit set:
  - Winner w is the first set bit scanning last+1, last+2, … modulo NREQ.
  - shreg <= data[w]; gnt_id <= w; last <= w; state <= SHIFT; cnt <= 0.
  - On the next cycle: ack[w]=1 for exactly one cycle, frame_start=1, ser_valid=1, ser_out=data[w][0].
- At a decision edge with no req: go to IDLE. All outputs are 0 except gnt_id, which holds its value.
- SHIFT:
  - ser_out = shreg[cnt]; ser_valid=1; frame_start=1 only when cnt=0.
  - cnt increments each cycle.
  - After cnt=WIDTH-1: go to GAP if GAP>0; otherwise this is a decision edge, which allows back-to-back frames with ser_valid continuously high.
- GAP: ser_valid=0, ser_out=0, frame_start=0, busy=1. Lasts exactly GAP cycles.
- Latency: req sampled at an IDLE edge gives its first bit on the next cycle. Frame-start to frame-start period is WIDTH+GAP cycles under continuous demand.
- Data sampling: data is sampled only at the grant edge. Later changes to data do not affect the frame in progress.
- Requester contract:
  - Hold req and data until ack is seen.
  - Drop req on the cycle after ack, or keep it high to request another word.
  - Because WIDTH>=2, a req still high after ack is a genuine new request and is not double-counted.
- req withdrawn before a decision edge: no grant, no ack.
- req changes between decision edges: ignored.
- Simultaneous requests: exactly one grant per decision edge. Under continuous demand no requester waits more than NREQ-1 frames.
- clr has priority over every other event at the same edge.

Test Plan:
- Single frame:
  - Stimulus: WIDTH=6, GAP=1; after reset, req=4'b0100 with data[2]=6'b101101 in IDLE.
  - Response, next cycle: ack=4'b0100, gnt_id=2, frame_start=1.
  - ser_out over 6 valid cycles = 1,0,1,1,0,1.
  - Then 1 cycle with ser_valid=0 and busy=1, then IDLE with busy=0.
- Full contention:
  - Stimulus: req=4'b1111 held, distinct words.
  - Response: grant order 0,1,2,3,0,1; frame_start every 7 cycles; each ack pulses exactly once per grant.
- Back-to-back:
  - Stimulus: GAP=0, req=4'b0011 held.
  - Response: ser_valid never drops; frame_start every 6 cycles; gnt_id alternates 0,1,0,1.
- Round-robin pointer:
  - Stimulus: grant to 1 completes; then req=4'b1001 at the decision edge.
  - Response: requester 3 granted before requester 0.
- Reset mid-frame:
  - Stimulus: clr=1 during bit 3 of a frame from requester 2.
  - Response, next cycle: all outputs 0 and busy=0.
  - After clr=0 with req=4'b0110: requester 1 granted first.
- Withdrawn request:
  - Stimulus: req[3] pulsed high for 2 cycles mid-frame, low again before the decision edge.
  - Response: ack[3] never asserts; block returns to IDLE after the gap.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a single LSB-first serializer.
// Each frame is WIDTH payload bits followed by GAP idle cycles.
module serial_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6,
  parameter int GAP   = 1,
  parameter int IDW   = 2
) (
  input  logic                    clk_i,
  input  logic                    clr_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   data_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [IDW-1:0]          gnt_id_o,
  output logic                    ser_out_o,
  output logic                    ser_valid_o,
  output logic                    frame_start_o,
  output logic                    busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gc_q, gc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic           decide;
  logic           win_vld;
  logic [IDW-1:0] win_id;

  // Scan starts just past the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    decide = 1'b0;
    case (state_q)
      S_IDLE:  decide = 1'b1;
      S_SHIFT: decide = (cnt_q == CNT_LAST) && (GAP == 0);
      S_GAP:   decide = (gc_q == GAP_LAST);
      default: decide = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gc_d    = gc_q;
    shreg_d = shreg_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_d   = '0;
    if (decide) begin
      cnt_d = '0;
      gc_d  = '0;
      if (win_vld) begin
        state_d        = S_SHIFT;
        shreg_d        = data_i[int'(win_id)*WIDTH +: WIDTH];
        gnt_d          = win_id;
        last_d         = win_id;
        ack_d[win_id]  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_GAP;
            gc_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP:   gc_d = gc_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gc_q    <= '0;
      shreg_q <= '0;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gc_q    <= gc_d;
      shreg_q <= shreg_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o         = ack_q;
  assign gnt_id_o      = gnt_q;
  assign ser_valid_o   = (state_q == S_SHIFT);
  assign ser_out_o     = (state_q == S_SHIFT) ? shreg_q[cnt_q] : 1'b0;
  assign frame_start_o = (state_q == S_SHIFT) && (cnt_q == '0);
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench: one instance with a 1-cycle gap, one with back-to-back frames.
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req, req0;
  logic [23:0] data;

  logic [3:0] ack, ack0;
  logic [1:0] gnt, gnt0;
  logic       sout, sv, fs, busy;
  logic       sout0, sv0, fs0, busy0;

  int checks = 0;
  int failures = 0;

  serial_tx_arbiter #(.NREQ(4), .WIDTH(6), .GAP(1), .IDW(2)) dut (
    .clk_i(clk), .clr_i(clr), .req_i(req), .data_i(data),
    .ack_o(ack), .gnt_id_o(gnt), .ser_out_o(sout), .ser_valid_o(sv),
    .frame_start_o(fs), .busy_o(busy)
  );

  serial_tx_arbiter #(.NREQ(4), .WIDTH(6), .GAP(0), .IDW(2)) dut0 (
    .clk_i(clk), .clr_i(clr), .req_i(req0), .data_i(data),
    .ack_o(ack0), .gnt_id_o(gnt0), .ser_out_o(sout0), .ser_valid_o(sv0),
    .frame_start_o(fs0), .busy_o(busy0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] w [4];
  logic [5:0] cap;
  logic       any_ack, any_fs, all_sv;
  int         exp_id;

  initial begin
    w[0] = 6'h15; w[1] = 6'h2A; w[2] = 6'b101101; w[3] = 6'h0C;
    data = {w[3], w[2], w[1], w[0]};
    req = '0; req0 = '0; clr = 1'b1;
    tick(); tick();
    clr = 1'b0;

    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {ack, gnt, sout, sv, fs}, 0);
    chk("rst_busy0", 32'(busy0), 0);

    // single frame from requester 2
    req = 4'b0100;
    tick();
    chk("sf_ack", 32'(ack), 32'h4);
    chk("sf_gnt", 32'(gnt), 2);
    chk("sf_fs", {fs, sv, sout}, 3'b111);
    req = '0;
    cap = '0; cap[0] = sout; any_ack = 1'b0; any_fs = 1'b0; all_sv = 1'b1;
    for (int b = 1; b < 6; b++) begin
      tick();
      cap[b] = sout; any_ack |= |ack; any_fs |= fs; all_sv &= sv;
    end
    chk("sf_word", 32'(cap), 32'b101101);
    chk("sf_mid", {any_ack, any_fs, all_sv}, 3'b001);
    tick();
    chk("sf_gap", {sv, sout, fs, busy}, 4'b0001);
    tick();
    chk("sf_idle", {busy, sv}, 0);
    chk("sf_gnt_hold", 32'(gnt), 2);

    // full contention after a fresh reset: order 0,1,2,3,0,1
    clr = 1'b1; tick(); clr = 1'b0;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_id = k % 4;
      chk("fc_gnt", 32'(gnt), 32'(exp_id));
      chk("fc_ack", 32'(ack), 32'(1 << exp_id));
      chk("fc_fs", 32'(fs), 1);
      cap = '0; cap[0] = sout; any_ack = 1'b0; any_fs = 1'b0;
      for (int b = 1; b < 6; b++) begin
        tick();
        cap[b] = sout; any_ack |= |ack; any_fs |= fs;
      end
      chk("fc_word", 32'(cap), 32'(w[exp_id]));
      tick();
      any_ack |= |ack; any_fs |= fs;
      chk("fc_gap", {sv, busy, any_ack, any_fs}, 4'b0100);
      if (k == 5) req = '0;
      tick();
    end
    chk("fc_idle", 32'(busy), 0);

    // last winner was 1: requester 3 goes before requester 0
    req = 4'b1001;
    tick();
    chk("rr_first", 32'(gnt), 3);
    chk("rr_ack3", 32'(ack), 32'h8);
    req = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    chk("rr_second", 32'(gnt), 0);
    chk("rr_ack0", {ack, fs}, 5'b00011);
    req = '0;
    for (int i = 0; i < 7; i++) tick();
    chk("rr_idle", 32'(busy), 0);

    // reset during bit 3 of a frame from requester 2
    req = 4'b0100;
    tick();
    chk("rm_gnt", 32'(gnt), 2);
    req = '0;
    tick(); tick(); tick();
    chk("rm_bit3", {sv, sout}, 2'b11);
    clr = 1'b1; req = 4'b0110;
    tick();
    chk("rm_clr", {ack, gnt, sout, sv, fs, busy}, 0);
    clr = 1'b0;
    tick();
    chk("rm_regrant", 32'(gnt), 1);
    chk("rm_ack", 32'(ack), 32'h2);
    req = '0;

    // req[3] pulses mid-frame and drops before the decision edge
    tick(); tick();
    any_ack = 1'b0;
    req = 4'b1000;
    tick(); any_ack |= ack[3];
    tick(); any_ack |= ack[3];
    req = '0;
    tick(); any_ack |= ack[3];
    tick(); any_ack |= ack[3];
    chk("wd_gap", {sv, busy}, 2'b01);
    tick(); any_ack |= ack[3];
    chk("wd_idle", {busy, sv}, 0);
    chk("wd_noack", 32'(any_ack), 0);
    chk("wd_gnt", 32'(gnt), 1);

    // back-to-back frames with no gap
    req0 = 4'b0011;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      chk("bb_gnt", 32'(gnt0), 32'(exp_id));
      chk("bb_start", {ack0, fs0, sv0}, {4'(1 << exp_id), 2'b11});
      all_sv = 1'b1; any_fs = 1'b0;
      for (int b = 1; b < 6; b++) begin
        tick();
        all_sv &= sv0; any_fs |= fs0;
      end
      chk("bb_body", {all_sv, any_fs}, 2'b10);
      if (k == 3) req0 = '0;
      tick();
    end
    chk("bb_idle", {busy0, sv0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
